// File: rtl/mcycle_sequencer.sv
// Multi-cycle control sequencer for an RV32I subset (add, sub, addi, lw, sw, beq, bne).
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and traps on illegal opcodes or memory timeouts.
module mcycle_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  EQ,
    input  logic                  imem_ready,
    input  logic                  mem_ready,
    output logic                  imem_req,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  IRen,
    output logic                  PCen,
    output logic                  PCsrc,
    output logic                  RegWrite,
    output logic                  ALUsrc,
    output logic [2:0]            ALUctrl,
    output logic [1:0]            ImmSrc,
    output logic                  ResultSrc,
    output logic                  trap,
    output logic [2:0]            state
);

    localparam int CW = $clog2(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [1:0] IMM_I   = 2'b00;
    localparam logic [1:0] IMM_S   = 2'b01;
    localparam logic [1:0] IMM_B   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_ALU_R  = 3'd0,
        C_ALU_I  = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4
    } class_e;

    state_e        state_q, state_d;
    class_e        class_q, class_d;
    logic [CW-1:0] wait_q, wait_d;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    class_e     dec_class_s;
    logic       dec_legal_s;
    logic       sel_alu_src_s;
    logic [2:0] sel_alu_ctrl_s;
    logic [1:0] sel_imm_s;
    logic       unused_instr_s;

    assign opcode_s       = instr[6:0];
    assign funct3_s       = instr[14:12];
    assign funct7_s       = instr[31:25];
    assign unused_instr_s = ^instr;
    assign state          = state_q;

    // Opcode/funct decode into an instruction class plus a legality flag.
    always_comb begin
        dec_legal_s = 1'b0;
        dec_class_s = C_ALU_R;
        case (opcode_s)
            OP_R: begin
                dec_class_s = C_ALU_R;
                if ((funct3_s == 3'b000) && ((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000))) begin
                    dec_legal_s = 1'b1;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            OP_I: begin
                dec_class_s = C_ALU_I;
                dec_legal_s = (funct3_s == 3'b000);
            end
            OP_LOAD: begin
                dec_class_s = C_LOAD;
                dec_legal_s = (funct3_s == 3'b010);
            end
            OP_STORE: begin
                dec_class_s = C_STORE;
                dec_legal_s = (funct3_s == 3'b010);
            end
            OP_BRANCH: begin
                dec_class_s = C_BRANCH;
                dec_legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b001);
            end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // ALU operand/operation and immediate format for the latched class; shared by EXEC and MEM.
    always_comb begin
        sel_alu_src_s  = 1'b0;
        sel_alu_ctrl_s = ALU_ADD;
        sel_imm_s      = IMM_I;
        case (class_q)
            C_ALU_R: begin
                sel_alu_ctrl_s = instr[30] ? ALU_SUB : ALU_ADD;
            end
            C_ALU_I, C_LOAD: begin
                sel_alu_src_s = 1'b1;
            end
            C_STORE: begin
                sel_alu_src_s = 1'b1;
                sel_imm_s     = IMM_S;
            end
            C_BRANCH: begin
                sel_alu_ctrl_s = ALU_SUB;
                sel_imm_s      = IMM_B;
            end
            default: sel_alu_src_s = 1'b0;
        endcase
    end

    // Next-state, wait counter and per-step control outputs.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        wait_d    = wait_q;
        imem_req  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        IRen      = 1'b0;
        PCen      = 1'b0;
        PCsrc     = 1'b0;
        RegWrite  = 1'b0;
        ALUsrc    = 1'b0;
        ALUctrl   = ALU_ADD;
        ImmSrc    = IMM_I;
        ResultSrc = 1'b0;
        trap      = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRen    = 1'b1;
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_legal_s) begin
                    class_d = dec_class_s;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                ALUsrc  = sel_alu_src_s;
                ALUctrl = sel_alu_ctrl_s;
                ImmSrc  = sel_imm_s;
                case (class_q)
                    C_BRANCH: begin
                        // PC still points at this branch, so a taken branch goes to PC+ImmOp.
                        PCen    = 1'b1;
                        PCsrc   = (funct3_s == 3'b000) ? EQ : ~EQ;
                        wait_d  = '0;
                        state_d = S_FETCH;
                    end
                    C_LOAD, C_STORE: begin
                        wait_d  = '0;
                        state_d = S_MEM;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (class_q == C_STORE);
                ALUsrc  = sel_alu_src_s;
                ALUctrl = sel_alu_ctrl_s;
                ImmSrc  = sel_imm_s;
                if (mem_ready) begin
                    if (class_q == C_STORE) begin
                        PCen    = 1'b1;
                        wait_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = (class_q == C_LOAD);
                PCen      = 1'b1;
                wait_d    = '0;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // State, class and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            class_q <= C_ALU_R;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Self-checking bench for mcycle_sequencer: directed table, corner sequences and
// randomized instructions checked cycle by cycle against a transaction-level model.
module tb_mcycle_sequencer;

    localparam int MW = 16;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        EQ, imem_ready, mem_ready;
    logic        imem_req, mem_req, mem_we, IRen, PCen, PCsrc, RegWrite, ALUsrc;
    logic [2:0]  ALUctrl;
    logic [1:0]  ImmSrc;
    logic        ResultSrc, trap;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;
    logic [31:0] cur_w;

    mcycle_sequencer #(.DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .EQ(EQ),
        .imem_ready(imem_ready), .mem_ready(mem_ready),
        .imem_req(imem_req), .mem_req(mem_req), .mem_we(mem_we), .IRen(IRen),
        .PCen(PCen), .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
        .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .trap(trap),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [17:0] FULL    = 18'h3FFFF;
    localparam logic [17:0] NO_ALU  = 18'h3FF03;
    localparam logic [17:0] NO_IMM  = 18'h3FFF3;

    // {state, imem_req, mem_req, mem_we, IRen, PCen, PCsrc, RegWrite, ALUsrc, ALUctrl, ImmSrc, ResultSrc, trap}
    function automatic logic [17:0] mk(input logic [2:0] st, input logic ireq, input logic mreq,
                                       input logic we, input logic iren, input logic pcen,
                                       input logic pcsrc, input logic rw, input logic asrc,
                                       input logic [2:0] actl, input logic [1:0] imm,
                                       input logic rsrc, input logic trp);
        return {st, ireq, mreq, we, iren, pcen, pcsrc, rw, asrc, actl, imm, rsrc, trp};
    endfunction

    function automatic logic [17:0] actual();
        return {state, imem_req, mem_req, mem_we, IRen, PCen, PCsrc, RegWrite, ALUsrc,
                ALUctrl, ImmSrc, ResultSrc, trap};
    endfunction

    // Model: instruction class from the listed legal encodings. -1 illegal, 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH.
    function automatic int classify(input logic [31:0] w);
        logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        if (op == 7'b0110011 && f3 == 3'd0 && (f7 == 7'b0000000 || f7 == 7'b0100000)) return 0;
        if (op == 7'b0010011 && f3 == 3'd0) return 1;
        if (op == 7'b0000011 && f3 == 3'd2) return 2;
        if (op == 7'b0100011 && f3 == 3'd2) return 3;
        if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) return 4;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [17:0] exp, input logic [17:0] msk);
        logic [17:0] act;
        act = actual();
        checks++;
        if (((act ^ exp) & msk) != 18'd0) begin
            errors++;
            $display("FAIL %s instr=%h got=%h want=%h mask=%h", nm, cur_w, act, exp, msk);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s instr=%h got=%0d want=%0d", nm, cur_w, got, want);
        end
    endtask

    // Called at posedge+1: apply inputs, check the combinational outputs, advance one clock.
    task automatic cyc(input logic ir, input logic mr, input logic e, input logic [31:0] w,
                       input logic [17:0] exp, input logic [17:0] msk, input string nm);
        imem_ready = ir; mem_ready = mr; EQ = e; instr = w;
        #1;
        chk(nm, exp, msk);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0; imem_ready = 1'b0; mem_ready = 1'b0;
        #1;
        chk("reset", mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0), FULL);
        @(posedge clk);
        #1;
        chk("reset_held", mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0), FULL);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic trap_hold();
        for (int k = 0; k < 20; k++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                mk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1), FULL, "trap");
        end
        reset_dut();
    endtask

    // One instruction: fw fetch wait cycles, mw memory wait cycles; a wait >= MW means no ready at all.
    task automatic run_txn(input logic [31:0] w, input int fw, input int mw, input logic eq,
                           output int ncyc, output bit trapped);
        int c; logic r; logic asrc; logic [2:0] actl; logic [1:0] imm; logic [17:0] emsk;
        logic pcsrc_exp; logic e;
        cur_w = w; ncyc = 0; trapped = 1'b0;
        c = classify(w);
        for (int k = 0; k <= fw && k < MW; k++) begin
            r = (k == fw);
            cyc(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (r ? w : $urandom),
                mk(3'd0, 1'b1, 1'b0, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0), FULL, "fetch");
            ncyc++;
        end
        if (fw >= MW) begin trapped = 1'b1; trap_hold(); return; end
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
            mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0), FULL, "decode");
        ncyc++;
        if (c < 0) begin trapped = 1'b1; trap_hold(); return; end
        asrc = (c == 1 || c == 2 || c == 3);
        actl = (c == 4 || (c == 0 && w[31:25] == 7'b0100000)) ? 3'b001 : 3'b000;
        imm  = (c == 3) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
        emsk = (c == 0) ? NO_IMM : FULL;
        e = (c == 4) ? eq : 1'($urandom_range(0, 1));
        pcsrc_exp = (c == 4) && ((w[14:12] == 3'b000) ? eq : !eq);
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, w,
            mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, (c == 4), pcsrc_exp, 1'b0, asrc, actl, imm, 1'b0, 1'b0),
            emsk, "exec");
        ncyc++;
        if (c == 4) return;
        if (c == 2 || c == 3) begin
            for (int k = 0; k <= mw && k < MW; k++) begin
                r = (k == mw);
                cyc(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)), w,
                    mk(3'd3, 1'b0, 1'b1, (c == 3), 1'b0, (c == 3) && r, 1'b0, 1'b0, asrc, actl, imm, 1'b0, 1'b0),
                    FULL, "mem");
                ncyc++;
            end
            if (mw >= MW) begin trapped = 1'b1; trap_hold(); return; end
            if (c == 3) return;
        end
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
            mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, (c == 2), 1'b0),
            NO_ALU, "wb");
        ncyc++;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w; int kind; int idx; int pos;
        w = $urandom;
        kind = $urandom_range(0, 4);
        case (kind)
            0: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000;
                     w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000; end
            1: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
            2: begin w[6:0] = 7'b0000011; w[14:12] = 3'b010; end
            3: begin w[6:0] = 7'b0100011; w[14:12] = 3'b010; end
            default: begin w[6:0] = 7'b1100011; w[14:12] = {2'b00, 1'($urandom_range(0, 1))}; end
        endcase
        if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, 16);
            pos = (idx < 7) ? idx : (idx < 10) ? idx + 5 : idx + 15;
            w[pos] = ~w[pos];
        end
        return w;
    endfunction

    typedef struct {
        logic [31:0] w;
        int          fw;
        int          mw;
        logic        eq;
        int          exp_cyc;
        bit          exp_trap;
    } vec_t;

    initial begin
        vec_t tbl[16];
        int n; bit t; int fw; int mw;
        logic [31:0] w;
        tbl[0]  = '{32'h00500093, 0, 0, 1'b0, 4, 1'b0};   // addi x1,x0,5
        tbl[1]  = '{32'h00012183, 0, 3, 1'b0, 8, 1'b0};   // lw, 3 memory wait cycles
        tbl[2]  = '{32'hFE209EE3, 0, 0, 1'b0, 3, 1'b0};   // bne, taken
        tbl[3]  = '{32'hFE209EE3, 0, 0, 1'b1, 3, 1'b0};   // bne, not taken
        tbl[4]  = '{32'h0021A023, 0, 0, 1'b0, 4, 1'b0};   // sw
        tbl[5]  = '{32'h002081B3, 0, 0, 1'b0, 4, 1'b0};   // add
        tbl[6]  = '{32'h402081B3, 0, 0, 1'b0, 4, 1'b0};   // sub
        tbl[7]  = '{32'h00208463, 0, 0, 1'b1, 3, 1'b0};   // beq, taken
        tbl[8]  = '{32'hFFFFFFFF, 0, 0, 1'b0, 2, 1'b1};   // illegal
        tbl[9]  = '{32'h00500093, 16, 0, 1'b0, 16, 1'b1}; // fetch never answered
        tbl[10] = '{32'h00500093, 15, 0, 1'b0, 19, 1'b0}; // fetch answered on last allowed cycle
        tbl[11] = '{32'h0021A023, 0, 15, 1'b0, 19, 1'b0}; // store answered on last allowed cycle
        tbl[12] = '{32'h00012183, 0, 16, 1'b0, 19, 1'b1}; // load never answered
        tbl[13] = '{32'h00012183, 2, 0, 1'b0, 7, 1'b0};   // lw with fetch waits
        tbl[14] = '{32'h00109093, 0, 0, 1'b0, 2, 1'b1};   // slli: illegal funct3
        tbl[15] = '{32'h022081B3, 0, 0, 1'b0, 2, 1'b1};   // mul: illegal funct7

        rst = 1'b0; instr = 32'd0; EQ = 1'b0; imem_ready = 1'b0; mem_ready = 1'b0; cur_w = 32'd0;
        @(posedge clk);
        #1;
        reset_dut();

        for (int i = 0; i < 16; i++) begin
            run_txn(tbl[i].w, tbl[i].fw, tbl[i].mw, tbl[i].eq, n, t);
            chk_int("latency", n, tbl[i].exp_cyc);
            chk_int("trapped", int'(t), int'(tbl[i].exp_trap));
        end

        // Reset in the middle of a load's MEM step drops the request with no retirement.
        w = 32'h00012183; cur_w = w;
        cyc(1'b1, 1'b0, 1'b0, w, mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0), FULL, "rm_fetch");
        cyc(1'b0, 1'b0, 1'b0, w, mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0), FULL, "rm_decode");
        cyc(1'b0, 1'b0, 1'b0, w, mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0), FULL, "rm_exec");
        imem_ready = 1'b1; mem_ready = 1'b0;
        #1;
        chk("rm_mem", mk(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0), FULL);
        rst = 1'b0; imem_ready = 1'b0; mem_ready = 1'b1;
        #1;
        chk("rm_reset", mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0), FULL);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_txn(32'h00500093, 0, 0, 1'b0, n, t);
        chk_int("rm_after", n, 4);

        for (int i = 0; i < 150; i++) begin
            fw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
            run_txn(gen_instr(), fw, mw, 1'($urandom_range(0, 1)), n, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcycle_sequencer.md
# mcycle_sequencer

Multi-cycle control sequencer for the RV32I datapath: PC register, instruction register, register file, ALU and data memory port. Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives per-step enables and mux selects. Handshakes with instruction and data memories that may insert wait states, and traps on illegal opcodes or memory timeouts. Supported subset: add, sub, addi, lw, sw, beq, bne.

## Interface
- DATA_WIDTH, 32, instruction width.
- MAX_WAIT, 16, cycles a memory request may stay unanswered before trapping (≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = in reset).
- instr  in  DATA_WIDTH  instruction register contents; stable from the cycle after IRen.
- EQ  in  1  ALU zero/equal flag, valid in EXEC.
- imem_ready  in  1  instruction memory has data this cycle.
- mem_ready  in  1  data memory completes access this cycle.
- imem_req  out  1  instruction fetch request.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write (only with mem_req).
- IRen  out  1  load instruction register.
- PCen  out  1  update PC.
- PCsrc  out  1  0 = PC+4, 1 = PC+ImmOp.
- RegWrite  out  1  register file write.
- ALUsrc  out  1  0 = rs2, 1 = ImmOp.
- ALUctrl  out  3  000 add, 001 sub.
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type.
- ResultSrc  out  1  0 = ALUout, 1 = load data.
- trap  out  1  sticky fault flag.
- state  out  3  current state code (debug).

## Operation
- States (codes): FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7.
- FETCH: imem_req=1. On imem_ready: IRen=1, -> DECODE. Otherwise stay.
- DECODE: classify instr into class register (ALU_R, ALU_I, LOAD, STORE, BRANCH). Legal: opcode 0110011 f3=000 f7∈{0000000,0100000}; 0010011 f3=000; 0000011 f3=010; 0100011 f3=010; 1100011 f3∈{000,001}. Illegal -> TRAP; else -> EXEC.
- EXEC: ALUsrc/ALUctrl/ImmSrc from class (R: 0/add or sub by f7 bit 30/xx; I, LOAD: 1/add/00; STORE: 1/add/01; BRANCH: 0/sub/10). ALU_R, ALU_I -> WB. LOAD, STORE -> MEM. BRANCH: PCen=1, PCsrc = (f3=000 ? EQ : !EQ), -> FETCH.
- MEM: mem_req=1, mem_we=1 for STORE, ALUsrc/ALUctrl/ImmSrc held as in EXEC. On mem_ready: STORE -> PCen=1, PCsrc=0, -> FETCH; LOAD -> WB.
- WB: RegWrite=1, ResultSrc = (class==LOAD), PCen=1, PCsrc=0, -> FETCH.
- PC is updated exactly once per instruction, at its final step; PC holds the current instruction address throughout, so branch target is PC+ImmOp.
- Wait counter: cleared on entering FETCH or MEM, increments each cycle in FETCH/MEM without ready. Ready in the cycle counter reaches MAX_WAIT-1 is accepted; no ready in that cycle -> TRAP.
- TRAP: all enables, requests and selects 0; trap=1; held until reset.
- Ready inputs outside their request state are ignored.

## Timing
- Outputs are combinational from state, class register, instr and the ready/EQ inputs; state, class and counter are registered.
- Reset (async, rst=0): state=FETCH, class=ALU_R, counter=0, trap=0. Hence during/after reset imem_req=1, all other outputs 0, state=0.
- rst asserted mid-MEM or mid-FETCH drops the pending request immediately; no PCen/RegWrite issued for the interrupted instruction.
- Zero-wait latency, first imem_req to next imem_req: branch 3, add/addi/sw 4, lw 5 cycles. Each wait cycle adds 1.
- Exactly one PCen pulse per retired instruction; RegWrite never coincides with mem_req.

## Test plan
- Reset then addi x1,x0,5 (0x00500093), imem_ready=1 always -> states 0,1,2,4,0; IRen in cycle 1, RegWrite+PCen(PCsrc=0) in cycle 4, ALUsrc=1 in EXEC.
- lw (0x00012183) with mem_ready delayed 3 cycles -> MEM held 4 cycles with mem_req=1, mem_we=0; WB has ResultSrc=1, RegWrite=1; total 8 cycles.
- bne (0xFE209EE3) with EQ=0 -> EXEC PCen=1, PCsrc=1; with EQ=1 -> PCsrc=0; no RegWrite; 3 cycles.
- sw (0x0021A023) -> MEM: mem_req=1, mem_we=1, ImmSrc=01; PCen on mem_ready; no WB.
- Illegal instr 0xFFFFFFFF -> TRAP after DECODE, trap=1, all enables 0 for 20 cycles; rst pulse low returns to FETCH with trap=0.
- MAX_WAIT=16, imem_ready held 0 -> TRAP entered after 16 FETCH cycles; repeat with ready on 16th cycle -> accepted, no trap.
